ay3891x_multi: RTL and testbench
================================

// Module: ay3891x_multi
// PURPOSE
//  Parametrised successor to the 3-voice PSG. Provides CHANNELS square-wave tone
//  voices with programmable period, 4-bit volume, per-voice tone/noise enables,
//  one shared 17-bit LFSR noise source, per-voice 1-bit PWM outputs and a summed
//  digital level. Sits on the CPU I/O bus behind the same two-port (a0) address/data
//  scheme, driving audio pins or a sigma-delta DAC.
// PARAMETERS
//  CHANNELS  3   number of tone voices (1..8)
//  CLK_DIV   16  clk cycles per generator tick (>=2)
//  PERIOD_W  12  tone period width in bits (9..12)
// PORTS
//  clk      in   1           system clock
//  reset    in   1           synchronous, active-high reset
//  a0       in   1           0 = address port, 1 = data port
//  wr_tick  in   1           one-cycle write strobe
//  wdata    in   8           write data
//  rd_tick  in   1           one-cycle read strobe
//  rdata    out  8           registered read data
//  aout     out  CHANNELS    per-voice PWM audio bit
//  level    out  LEVEL_W     sum of active voice volumes; LEVEL_W=4+$clog2(CHANNELS+1)
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: all regs 0, addr 0, prescaler/tone/noise/PWM counters 0, square bits 0,
//   LFSR 17'h00001, rdata 0, aout 0, level 0.
//  Bus: wr_tick&a0=0 -> addr<=wdata. wr_tick&a0=1 -> reg[addr]<=wdata (masked).
//   rd_tick&a0=1 -> rdata<=reg[addr] next cycle, unused bits 0; a0=0 read -> addr.
//   Unmapped addr: writes ignored, reads 0. Same-cycle wr&rd: rdata gets pre-write value.
//  Map, voice n: 4n period lo[7:0]; 4n+1 period hi[PERIOD_W-9:0]; 4n+2 volume[3:0];
//   4n+3 ctrl: b0 tone_en, b1 noise_en. Addr 4*CHANNELS: noise period[4:0].
//  Prescaler: counts 0..CLK_DIV-1; tick asserted for the cycle where cnt==CLK_DIV-1.
//  Tone n, on tick: eff=max(period,1); if cnt>=eff-1 then cnt<=0, sq^=1 else cnt+1.
//   ">=" compare: period shortened below cnt wraps on next tick (no long wrap).
//  Noise, on tick: same counter rule with 5-bit period (0 treated as 1); on wrap
//   lfsr<={lfsr[0]^lfsr[3], lfsr[16:1]} (taps x^17+x^14+1). LFSR never all-zero.
//  Gate n = (tone_en ? sq : 1) & (noise_en ? lfsr[0] : 1) (both off -> constant 1).
//  PWM: free-running counter 0..14 at clk rate; pwm_n = (pcnt < vol_n); vol 15 ->
//   always 1, vol 0 -> always 0. aout[n] registered = gate_n & pwm_n (1-cycle latency).
//  level registered = sum over n of (gate_n ? vol_n : 0); max 15*CHANNELS, no overflow.
//  Register writes affect generators from the next clk; counters keep running.
//  Reset mid-operation: all state returns to reset values on the next edge.
// TESTING
//  reset 4 cycles -> rdata=0, aout=0, level=0, regs read back 0.
//  CLK_DIV=4: ch0 period=2, vol=15, ctrl=1 -> aout[0] toggles every 8 clk, level 0/15.
//  ch1 period 0x123, read addr 4/5 -> 0x23 / 0x01; write 0xFF to addr 5 reads 0x0F (W=12).
//  ch0 vol=5, gate 1 -> aout[0] high 5 of every 15 clk; vol=0 -> aout[0] stays 0.
//  ctrl=2, noise period 1 -> aout follows lfsr[0]; first 17 lfsr[0] values match model.
//  all 3 voices vol=15, ctrl=0 -> level=45; write addr 0x40 then read -> 0, no effect.

Source files
------------

// File: rtl/ay3891x_multi.sv
// Multi-voice square-wave PSG with shared LFSR noise, per-voice PWM bits and summed level.
// Ports: clk/reset, a0/wr_tick/wdata/rd_tick bus, rdata, aout[CHANNELS], level[LEVEL_W].
module ay3891x_multi #(
  parameter int CHANNELS = 3,
  parameter int CLK_DIV  = 16,
  parameter int PERIOD_W = 12,
  localparam int LEVEL_W = 4 + $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a0,
  input  logic                wr_tick,
  input  logic [7:0]          wdata,
  input  logic                rd_tick,
  output logic [7:0]          rdata,
  output logic [CHANNELS-1:0] aout,
  output logic [LEVEL_W-1:0]  level
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int HW = PERIOD_W - 8;
  localparam logic [7:0] NADDR = 8'(4 * CHANNELS);

  logic [7:0]          addr_q, rdata_q, rd_val;
  logic [7:0]          plo_q  [CHANNELS];
  logic [HW-1:0]       phi_q  [CHANNELS];
  logic [3:0]          vol_q  [CHANNELS];
  logic [1:0]          ctl_q  [CHANNELS];
  logic [4:0]          nper_q;

  logic [PW-1:0]       pre_q, pre_d;
  logic                tick;
  logic [PERIOD_W-1:0] tcnt_q [CHANNELS];
  logic [PERIOD_W-1:0] tcnt_d [CHANNELS];
  logic [PERIOD_W-1:0] tlim   [CHANNELS];
  logic [CHANNELS-1:0] sq_q, sq_d, gate;
  logic [4:0]          ncnt_q, ncnt_d, nlim;
  logic [16:0]         lfsr_q, lfsr_d;
  logic [3:0]          pcnt_q, pcnt_d;
  logic [CHANNELS-1:0] aout_q, aout_d;
  logic [LEVEL_W-1:0]  level_q, level_d;

  always_comb begin
    rd_val = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (addr_q[7:2] == 6'(n)) begin
        case (addr_q[1:0])
          2'd0:    rd_val = plo_q[n];
          2'd1:    rd_val = 8'(phi_q[n]);
          2'd2:    rd_val = {4'b0, vol_q[n]};
          default: rd_val = {6'b0, ctl_q[n]};
        endcase
      end
    end
    if (addr_q == NADDR) rd_val = {3'b0, nper_q};
  end

  always_comb begin
    tick   = (pre_q == PW'(CLK_DIV - 1));
    pre_d  = tick ? '0 : pre_q + PW'(1);
    sq_d   = sq_q;
    gate   = '0;
    aout_d = '0;
    level_d = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      tcnt_d[n] = tcnt_q[n];
      // Period 0 behaves as 1; ">=" lets a shortened period wrap at once.
      tlim[n] = ({phi_q[n], plo_q[n]} == '0) ? '0
              : {phi_q[n], plo_q[n]} - PERIOD_W'(1);
      if (tick) begin
        if (tcnt_q[n] >= tlim[n]) begin
          tcnt_d[n] = '0;
          sq_d[n]   = ~sq_q[n];
        end else begin
          tcnt_d[n] = tcnt_q[n] + PERIOD_W'(1);
        end
      end
      gate[n] = (ctl_q[n][0] ? sq_q[n] : 1'b1)
              & (ctl_q[n][1] ? lfsr_q[0] : 1'b1);
      aout_d[n] = gate[n] & (pcnt_q < vol_q[n]);
      if (gate[n]) level_d = level_d + LEVEL_W'(vol_q[n]);
    end
    ncnt_d = ncnt_q;
    lfsr_d = lfsr_q;
    nlim   = (nper_q == '0) ? '0 : nper_q - 5'd1;
    if (tick) begin
      if (ncnt_q >= nlim) begin
        ncnt_d = '0;
        lfsr_d = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
      end else begin
        ncnt_d = ncnt_q + 5'd1;
      end
    end
    pcnt_d = (pcnt_q == 4'd14) ? 4'd0 : pcnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      rdata_q <= '0;
      nper_q  <= '0;
      pre_q   <= '0;
      sq_q    <= '0;
      ncnt_q  <= '0;
      lfsr_q  <= 17'h00001;
      pcnt_q  <= '0;
      aout_q  <= '0;
      level_q <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        plo_q[n]  <= '0;
        phi_q[n]  <= '0;
        vol_q[n]  <= '0;
        ctl_q[n]  <= '0;
        tcnt_q[n] <= '0;
      end
    end else begin
      if (wr_tick && !a0) addr_q <= wdata;
      for (int n = 0; n < CHANNELS; n++) begin
        if (wr_tick && a0 && addr_q[7:2] == 6'(n)) begin
          case (addr_q[1:0])
            2'd0:    plo_q[n] <= wdata;
            2'd1:    phi_q[n] <= wdata[HW-1:0];
            2'd2:    vol_q[n] <= wdata[3:0];
            default: ctl_q[n] <= wdata[1:0];
          endcase
        end
        tcnt_q[n] <= tcnt_d[n];
      end
      if (wr_tick && a0 && addr_q == NADDR) nper_q <= wdata[4:0];
      if (rd_tick) rdata_q <= a0 ? rd_val : addr_q;
      pre_q   <= pre_d;
      sq_q    <= sq_d;
      ncnt_q  <= ncnt_d;
      lfsr_q  <= lfsr_d;
      pcnt_q  <= pcnt_d;
      aout_q  <= aout_d;
      level_q <= level_d;
    end
  end

  assign rdata = rdata_q;
  assign aout  = aout_q;
  assign level = level_q;
endmodule

// File: tb/tb_ay3891x_multi.sv
// Scoreboard bench for ay3891x_multi (3 voices, CLK_DIV=4, 12-bit periods).
// Stimulus pushes expectations; a negedge monitor pops on read or sample strobes.
`timescale 1ns/1ps
module tb_ay3891x_multi;
  localparam int CH = 3;
  localparam int LW = 4 + $clog2(CH + 1);

  logic          clk = 0, reset = 1, a0 = 0;
  logic          wr_tick = 0, rd_tick = 0;
  logic [7:0]    wdata = 0, rdata;
  logic [CH-1:0] aout;
  logic [LW-1:0] level;

  ay3891x_multi #(.CHANNELS(CH), .CLK_DIV(4), .PERIOD_W(12)) dut (
    .clk(clk), .reset(reset), .a0(a0), .wr_tick(wr_tick),
    .wdata(wdata), .rd_tick(rd_tick), .rdata(rdata),
    .aout(aout), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] ea;
    logic [7:0] eb;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0, ecnt = 0;
  logic rd_seen = 0, chk = 0;
  exp_t me;
  logic mok;

  always @(posedge clk) begin
    rd_seen <= rd_tick;
    ecnt    <= reset ? 0 : ecnt + 1;
  end

  task automatic check_one();
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_underflow: output seen with no expected entry");
    end else begin
      me = sb.pop_front();
      case (me.kind)
        0:       mok = (rdata == me.ea);
        default: mok = (aout == me.ea[CH-1:0]) && (level == me.eb[LW-1:0]);
      endcase
      n_vec++;
      if (!mok) begin
        n_err++;
        $display("FAIL %s: got rdata=%h aout=%b level=%0d, want a=%h b=%0d",
                 me.name, rdata, aout, level, me.ea, me.eb);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rd_seen) check_one();
    if (chk) check_one();
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input int k, input logic [7:0] a,
                      input logic [7:0] b, input string nm);
    exp_t e;
    e.kind = k; e.ea = a; e.eb = b; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wr(input logic p, input logic [7:0] d);
    a0 = p; wdata = d; wr_tick = 1;
    cyc();
    wr_tick = 0;
  endtask

  task automatic setreg(input logic [7:0] ad, input logic [7:0] d);
    wr(0, ad);
    wr(1, d);
  endtask

  task automatic rd(input logic p, input logic [7:0] e, input string nm);
    a0 = p; rd_tick = 1;
    push(0, e, 8'd0, nm);
    cyc();
    rd_tick = 0;
  endtask

  task automatic look(input int k, input logic [7:0] a,
                      input logic [7:0] b, input string nm);
    push(k, a, b, nm);
    chk = 1;
    cyc();
    chk = 0;
  endtask

  task automatic wait_a0(input logic lvl, input string nm);
    int g = 0;
    while (aout[0] !== lvl && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      n_vec++; n_err++;
      $display("FAIL %s: aout[0] never reached %b", nm, lvl);
    end
  endtask

  function automatic logic [16:0] lstep(input logic [16:0] v);
    return {v[0] ^ v[3], v[16:1]};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] m;
    logic        b;
    int          g;

    reset = 1;
    repeat (4) cyc();
    look(2, 8'd0, 8'd0, "rst_out");
    look(0, 8'd0, 8'd0, "rst_rdata");
    reset = 0;

    for (int a = 0; a <= 12; a++) begin
      wr(0, 8'(a));
      rd(1, 8'h00, "rst_reg");
    end

    setreg(8'd4, 8'h23);
    setreg(8'd5, 8'h01);
    wr(0, 8'd4);
    rd(1, 8'h23, "per_lo");
    wr(0, 8'd5);
    rd(1, 8'h01, "per_hi");
    wr(1, 8'hFF);
    rd(1, 8'h0F, "per_hi_mask");
    rd(0, 8'h05, "addr_read");
    setreg(8'd12, 8'hFF);
    rd(1, 8'h1F, "nper_mask");
    setreg(8'd13, 8'h5A);
    rd(1, 8'h00, "unmapped13");
    setreg(8'd7, 8'hFC);
    rd(1, 8'h00, "ctrl_mask");

    wr(0, 8'd4);
    a0 = 1; wdata = 8'h77; wr_tick = 1; rd_tick = 1;
    push(0, 8'h23, 8'd0, "wr_rd_same");
    cyc();
    wr_tick = 0; rd_tick = 0;
    rd(1, 8'h77, "after_wr");

    setreg(8'd0, 8'd2);
    setreg(8'd1, 8'd0);
    setreg(8'd3, 8'd1);
    setreg(8'd2, 8'd15);
    @(negedge clk);
    wait_a0(1, "tone_sync");
    wait_a0(0, "tone_sync");
    wait_a0(1, "tone_sync");
    cyc();
    for (int k = 1; k <= 16; k++) begin
      b = (k < 8) || (k == 16);
      look(2, {7'd0, b}, b ? 8'd15 : 8'd0, "tone_p2");
    end

    setreg(8'd3, 8'd0);
    setreg(8'd2, 8'd5);
    @(negedge clk);
    wait_a0(0, "pwm_sync");
    wait_a0(1, "pwm_sync");
    cyc();
    for (int k = 1; k <= 15; k++) begin
      b = (k < 5) || (k == 15);
      look(2, {7'd0, b}, 8'd5, "pwm_v5");
    end

    setreg(8'd2, 8'd0);
    cyc();
    for (int k = 0; k < 15; k++) look(2, 8'd0, 8'd0, "pwm_v0");

    wr(0, 8'd4);
    rd(1, 8'h77, "pre_reset_rd");
    reset = 1;
    cyc();
    cyc();
    look(2, 8'd0, 8'd0, "midrst_out");
    look(0, 8'd0, 8'd0, "midrst_rdata");
    reset = 0;

    setreg(8'd3, 8'd2);
    setreg(8'd2, 8'd15);
    setreg(8'd12, 8'd1);
    m = 17'h00001;
    for (int s = 1; s <= 17; s++) begin
      m = lstep(m);
      g = 0;
      while (ecnt != 4 * s + 2 && g < 20) begin
        cyc();
        g++;
      end
      if (g >= 20) begin
        n_vec++; n_err++;
        $display("FAIL lfsr_sync: cycle %0d not reached", 4 * s + 2);
      end
      look(2, {7'd0, m[0]}, m[0] ? 8'd15 : 8'd0, "lfsr_seq");
    end

    setreg(8'd3, 8'd0);
    setreg(8'd6, 8'd15);
    setreg(8'd10, 8'd15);
    cyc();
    for (int k = 0; k < 3; k++) look(2, 8'h07, 8'd45, "all_max");
    setreg(8'h40, 8'hAA);
    rd(1, 8'h00, "unmapped40");
    rd(0, 8'h40, "addr40");
    look(2, 8'h07, 8'd45, "all_max_after");

    repeat (3) cyc();
    if (sb.size() != 0) begin
      n_vec += sb.size();
      n_err += sb.size();
      $display("FAIL sb_drain: %0d entries never checked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
